// File: rtl/ps2_pkg.sv
// Shared frame layout, scan constants, FSM states and frame helpers for the
// PS/2 receive path.
package ps2_pkg;

   localparam int unsigned START_BIT  = 10;
   localparam int unsigned DATA_MSB   = 9;
   localparam int unsigned DATA_LSB   = 2;
   localparam int unsigned PARITY_BIT = 1;
   localparam int unsigned STOP_BIT   = 0;

   localparam logic [7:0] BREAK_CODE = 8'hF0;
   localparam logic [7:0] EXT_CODE   = 8'hE0;

   typedef enum logic [1:0] {IDLE, SHIFT, CHECK} state_e;

   // d0 travels first, so it lands at the top of the data field.
   function automatic logic [7:0] frame_data(input logic [10:0] frame);
      logic [7:0] d;
      for (int i = 0; i < 8; i++) begin
         d[i] = frame[DATA_MSB - i];
      end
      return d;
   endfunction

   function automatic logic frame_ok(input logic [10:0] frame);
      return !frame[START_BIT] && frame[STOP_BIT] && (^frame[DATA_MSB:PARITY_BIT]);
   endfunction

endpackage

// File: rtl/ps2_line_filter.sv
// Two-flop synchronizer plus run-length glitch filter for one PS/2 line;
// emits a one-cycle pulse when the filtered level falls.
module ps2_line_filter #(
   parameter int unsigned FILTER_LEN = 8
) (
   input  logic clk,
   input  logic rst_n,
   input  logic raw,
   output logic fall
);

   localparam int unsigned CW = $clog2(FILTER_LEN + 1);

   logic          sync1_q;
   logic          sync2_q;
   logic          level_q;
   logic          fall_q;
   logic [CW-1:0] cnt_q;

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         sync1_q <= 1'b1;
         sync2_q <= 1'b1;
         level_q <= 1'b1;
         fall_q  <= 1'b0;
         cnt_q   <= '0;
      end else begin
         sync1_q <= raw;
         sync2_q <= sync1_q;
         fall_q  <= 1'b0;
         if (sync2_q != level_q) begin
            // Toggle on the FILTER_LEN-th consecutive disagreeing sample.
            if (cnt_q == CW'(FILTER_LEN - 1)) begin
               level_q <= sync2_q;
               fall_q  <= level_q;
               cnt_q   <= '0;
            end else begin
               cnt_q <= cnt_q + CW'(1);
            end
         end else begin
            cnt_q <= '0;
         end
      end
   end

   assign fall = fall_q;

endmodule

// File: rtl/ps2_frame_ctrl.sv
// PS/2 receive controller: assembles 11-bit frames, validates them, tracks
// break prefixes and presents accepted make frames to the button decoder.
module ps2_frame_ctrl
   import ps2_pkg::*;
#(
   parameter int unsigned FILTER_LEN     = 8,
   parameter int unsigned TIMEOUT_CYCLES = 100000,
   parameter bit          CLR_ON_BREAK   = 1'b1
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        ps2_clk,
   input  logic        ps2_data,
   output logic [10:0] frame_o,
   output logic        frame_valid,
   output logic        break_o,
   output logic        err_o,
   output logic        busy_o
);

   localparam int unsigned TW = $clog2(TIMEOUT_CYCLES + 1);

   logic          clk_fall;
   logic          dsync1_q;
   logic          dsync2_q;
   logic          edge_q;
   logic          bit_q;
   logic          pend_q;
   logic          brk_pend_q;
   state_e        state_q;
   logic [10:0]   shift_q;
   logic [3:0]    cnt_q;
   logic [TW-1:0] tmo_q;
   logic [10:0]   frame_next;

   ps2_line_filter #(
      .FILTER_LEN(FILTER_LEN)
   ) u_clk_filter (
      .clk  (clk),
      .rst_n(rst_n),
      .raw  (ps2_clk),
      .fall (clk_fall)
   );

   assign frame_next = {shift_q[9:0], bit_q};

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         dsync1_q    <= 1'b1;
         dsync2_q    <= 1'b1;
         edge_q      <= 1'b0;
         bit_q       <= 1'b1;
         pend_q      <= 1'b0;
         brk_pend_q  <= 1'b0;
         state_q     <= IDLE;
         shift_q     <= '0;
         cnt_q       <= '0;
         tmo_q       <= '0;
         frame_o     <= '0;
         frame_valid <= 1'b0;
         break_o     <= 1'b0;
         err_o       <= 1'b0;
         busy_o      <= 1'b0;
      end else begin
         dsync1_q    <= ps2_data;
         dsync2_q    <= dsync1_q;
         edge_q      <= clk_fall;
         bit_q       <= dsync2_q;
         frame_valid <= 1'b0;
         break_o     <= 1'b0;
         err_o       <= 1'b0;
         unique case (state_q)
            IDLE: begin
               if ((edge_q && !bit_q) || pend_q) begin
                  shift_q <= '0;
                  cnt_q   <= 4'd1;
                  tmo_q   <= '0;
                  busy_o  <= 1'b1;
                  pend_q  <= 1'b0;
                  state_q <= SHIFT;
               end
            end
            SHIFT: begin
               if (edge_q) begin
                  shift_q <= frame_next;
                  cnt_q   <= cnt_q + 4'd1;
                  tmo_q   <= '0;
                  // Decide on the 11th bit so strobes coincide with the CHECK cycle.
                  if (cnt_q == 4'd10) begin
                     state_q <= CHECK;
                     if (!frame_ok(frame_next)) begin
                        err_o <= 1'b1;
                     end else if (frame_data(frame_next) == BREAK_CODE) begin
                        brk_pend_q <= 1'b1;
                     end else if (frame_data(frame_next) != EXT_CODE) begin
                        if (brk_pend_q) begin
                           brk_pend_q <= 1'b0;
                           break_o    <= 1'b1;
                           if (CLR_ON_BREAK) frame_o <= '0;
                        end else begin
                           frame_o     <= frame_next;
                           frame_valid <= 1'b1;
                        end
                     end
                  end
               end else if (tmo_q == TW'(TIMEOUT_CYCLES)) begin
                  err_o   <= 1'b1;
                  busy_o  <= 1'b0;
                  state_q <= IDLE;
               end else begin
                  tmo_q <= tmo_q + TW'(1);
               end
            end
            CHECK: begin
               busy_o  <= 1'b0;
               state_q <= IDLE;
               // A start edge landing here must survive into IDLE.
               if (edge_q && !bit_q) pend_q <= 1'b1;
            end
            default: state_q <= IDLE;
         endcase
      end
   end

endmodule
